// File: rtl/arm_pkg.sv
// Shared types and constants for the ARM data-processing execute sequencer.
// Holds the FSM state encoding, ALU opcode map, condition codes and NZCV bit positions.
package arm_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StCond,
      StRead,
      StExec,
      StWb
   } seq_state_e;

   localparam logic [4:0] ALU_AND    = 5'h00;
   localparam logic [4:0] ALU_EOR    = 5'h01;
   localparam logic [4:0] ALU_SUB    = 5'h02;
   localparam logic [4:0] ALU_RSB    = 5'h03;
   localparam logic [4:0] ALU_ADD    = 5'h04;
   localparam logic [4:0] ALU_ADC    = 5'h05;
   localparam logic [4:0] ALU_SBC    = 5'h06;
   localparam logic [4:0] ALU_RSC    = 5'h07;
   localparam logic [4:0] ALU_TST    = 5'h08;
   localparam logic [4:0] ALU_TEQ    = 5'h09;
   localparam logic [4:0] ALU_CMP    = 5'h0A;
   localparam logic [4:0] ALU_CMN    = 5'h0B;
   localparam logic [4:0] ALU_ORR    = 5'h0C;
   localparam logic [4:0] ALU_MOV    = 5'h0D;
   localparam logic [4:0] ALU_BIC    = 5'h0E;
   localparam logic [4:0] ALU_MVN    = 5'h0F;
   localparam logic [4:0] ALU_BYPASS = 5'h10;

   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;
   localparam logic [3:0] COND_NV = 4'hF;

   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

   // TST/TEQ/CMP/CMN occupy opcodes 10xx: flags only, never a register write.
   function automatic logic is_test_op(input logic [3:0] opc);
      return opc[3:2] == 2'b10;
   endfunction

   function automatic logic [4:0] alu_op_map(input logic [3:0] opc);
      return ({1'b0, opc} == ALU_MOV) ? ALU_BYPASS : {1'b0, opc};
   endfunction

endpackage

// File: rtl/arm_cond_check.sv
// Combinational ARM condition-code evaluator: decides whether an instruction executes
// given its cond field and the current NZCV flags.
module arm_cond_check
   import arm_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] nzcv,
   output logic       pass
);

   logic n, z, c, v;

   assign n = nzcv[FLAG_N];
   assign z = nzcv[FLAG_Z];
   assign c = nzcv[FLAG_C];
   assign v = nzcv[FLAG_V];

   always_comb begin
      pass = 1'b0;
      unique case (cond)
         COND_EQ: pass = z;
         COND_NE: pass = ~z;
         COND_CS: pass = c;
         COND_CC: pass = ~c;
         COND_MI: pass = n;
         COND_PL: pass = ~n;
         COND_VS: pass = v;
         COND_VC: pass = ~v;
         COND_HI: pass = c & ~z;
         COND_LS: pass = ~c | z;
         COND_GE: pass = (n == v);
         COND_LT: pass = (n != v);
         COND_GT: pass = ~z & (n == v);
         COND_LE: pass = z | (n != v);
         COND_AL: pass = 1'b1;
         COND_NV: pass = 1'b0;
      endcase
   end

endmodule

// File: rtl/arm_dp_sequencer.sv
// Multi-cycle execute controller for ARM data-processing instructions. Walks each accepted
// instruction through condition check, operand read, ALU drive and writeback; owns NZCV.
module arm_dp_sequencer
   import arm_pkg::*;
#(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned REG_AW   = 4,
   parameter int unsigned ALU_OP_W = 5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                instr_valid,
   input  logic [31:0]         instr,
   output logic                instr_ready,
   output logic                done,
   output logic [REG_AW-1:0]   rf_ra,
   output logic [REG_AW-1:0]   rf_rb,
   input  logic [DATA_W-1:0]   rf_da,
   input  logic [DATA_W-1:0]   rf_db,
   output logic                rf_we,
   output logic [REG_AW-1:0]   rf_wa,
   output logic [DATA_W-1:0]   rf_wd,
   output logic                pc_wr,
   output logic [DATA_W-1:0]   alu_a,
   output logic [DATA_W-1:0]   alu_b,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic                alu_s,
   output logic                alu_oe,
   output logic [3:0]          alu_flags,
   input  logic [DATA_W-1:0]   alu_res,
   input  logic [3:0]          alu_flags_o,
   output logic [3:0]          flags
);

   seq_state_e  state;
   logic [31:0] instr_q;
   logic [3:0]  res_flags_q;

   logic [3:0] f_cond;
   logic       f_imm;
   logic [3:0] f_opc;
   logic       f_s;
   logic [3:0] f_rn;
   logic [3:0] f_rd;
   logic [3:0] f_rm;
   logic       test_op;
   logic       flag_upd;
   logic       cond_pass;

   assign f_cond   = instr_q[31:28];
   assign f_imm    = instr_q[25];
   assign f_opc    = instr_q[24:21];
   assign f_s      = instr_q[20];
   assign f_rn     = instr_q[19:16];
   assign f_rd     = instr_q[15:12];
   assign f_rm     = instr_q[3:0];
   assign test_op  = is_test_op(f_opc);
   assign flag_upd = f_s | test_op;

   // Rotate-right of the zero-extended imm8 by twice the rot field; the low half of the
   // doubled vector shifted right is exactly the rotation.
   logic [DATA_W-1:0]   imm_ext;
   logic [4:0]          rot_amt;
   logic [2*DATA_W-1:0] imm_dbl;
   logic [DATA_W-1:0]   imm_rot;

   assign imm_ext = DATA_W'(instr_q[7:0]);
   assign rot_amt = {instr_q[11:8], 1'b0};
   assign imm_dbl = {imm_ext, imm_ext} >> rot_amt;
   assign imm_rot = imm_dbl[DATA_W-1:0];

   logic unused_bits;
   assign unused_bits = ^{instr_q[27:26], imm_dbl[2*DATA_W-1:DATA_W]};

   arm_cond_check u_cond_check (
      .cond (f_cond),
      .nzcv (flags),
      .pass (cond_pass)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= StIdle;
         instr_q     <= '0;
         res_flags_q <= '0;
         flags       <= '0;
         instr_ready <= 1'b1;
         done        <= 1'b0;
         rf_ra       <= '0;
         rf_rb       <= '0;
         rf_we       <= 1'b0;
         rf_wa       <= '0;
         rf_wd       <= '0;
         pc_wr       <= 1'b0;
         alu_a       <= '0;
         alu_b       <= '0;
         alu_op      <= '0;
         alu_s       <= 1'b0;
         alu_oe      <= 1'b0;
         alu_flags   <= '0;
      end else begin
         // Strobes are single-cycle; only the state that owns them re-asserts them.
         done   <= 1'b0;
         rf_we  <= 1'b0;
         pc_wr  <= 1'b0;
         alu_oe <= 1'b0;
         alu_s  <= 1'b0;

         unique case (state)
            StIdle: begin
               if (instr_valid && instr_ready) begin
                  instr_q     <= instr;
                  instr_ready <= 1'b0;
                  state       <= StCond;
               end
            end

            StCond: begin
               if (cond_pass) begin
                  rf_ra <= REG_AW'(f_rn);
                  rf_rb <= REG_AW'(f_rm);
                  state <= StRead;
               end else begin
                  done        <= 1'b1;
                  instr_ready <= 1'b1;
                  state       <= StIdle;
               end
            end

            StRead: begin
               alu_a     <= rf_da;
               alu_b     <= f_imm ? imm_rot : rf_db;
               alu_op    <= ALU_OP_W'(alu_op_map(f_opc));
               alu_flags <= flags;
               alu_oe    <= 1'b1;
               alu_s     <= flag_upd;
               rf_ra     <= '0;
               rf_rb     <= '0;
               state     <= StExec;
            end

            StExec: begin
               res_flags_q <= alu_flags_o;
               rf_we       <= ~test_op;
               rf_wa       <= REG_AW'(f_rd);
               rf_wd       <= alu_res;
               pc_wr       <= ~test_op & (f_rd == 4'hF);
               done        <= 1'b1;
               alu_a       <= '0;
               alu_b       <= '0;
               alu_op      <= '0;
               alu_flags   <= '0;
               state       <= StWb;
            end

            StWb: begin
               // Committed at the end of WB so the next instruction's COND sees it.
               if (flag_upd) begin
                  flags <= res_flags_q;
               end
               rf_wa       <= '0;
               rf_wd       <= '0;
               instr_ready <= 1'b1;
               state       <= StIdle;
            end

            default: begin
               instr_ready <= 1'b1;
               state       <= StIdle;
            end
         endcase
      end
   end

endmodule
